// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: data width and the
// capture FSM state encoding used by the receive controller.
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_CLR  = 2'b01,
      S_WAIT = 2'b10
   } cap_state_t;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Consumer-facing bus of the receive controller: byte stream with
// valid/ready, occupancy, overrun status/clear and the line-idle event.
interface uart_rx_ctrl_if #(
   parameter int DEPTH = 8
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [uart_pkg::DATA_W-1:0] m_data;
   logic                        m_valid;
   logic                        m_ready;
   logic [CNT_W-1:0]            count;
   logic                        overrun;
   logic                        ovr_clr;
   logic                        idle_irq;

   modport master (
      output m_data, m_valid, count, overrun, idle_irq,
      input  m_ready, ovr_clr
   );

   modport slave (
      input  m_data, m_valid, count, overrun, idle_irq,
      output m_ready, ovr_clr
   );

endinterface

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO; the head byte reads as zero while empty
// so the output is well defined after reset without clearing the storage.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DATA_W-1:0]          wdata,
   input  logic                       pop,
   output logic [DATA_W-1:0]          rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [CNT_W-1:0]  cnt;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   assign empty = (cnt == '0);
   assign full  = (cnt == CNT_W'(DEPTH));
   assign count = cnt;
   assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: acknowledges the UART receiver, buffers bytes,
// tracks overrun and signals when buffered data sits unread on an idle line.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int IDLE_TICKS = 160
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              baud_tick2,
   input  logic              rx_line,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_rdy,
   output logic              rx_rdy_clr,
   uart_rx_ctrl_if.master    m
);

   localparam int TMR_W = $clog2(IDLE_TICKS + 1);

   cap_state_t       state;
   logic             capture;
   logic             push;
   logic             pop;
   logic             drop;
   logic             full;
   logic             empty;
   logic             ovr_q;
   logic             irq_q;
   logic             armed;
   logic [TMR_W-1:0] timer;

   // S_WAIT may see a fresh byte completed in the same cycle as the clear
   assign capture = rx_rdy && ((state == S_IDLE) || (state == S_WAIT));
   assign pop     = m.m_valid && m.m_ready;
   assign push    = capture && (!full || pop);
   assign drop    = capture && full && !pop;

   uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (rx_data),
      .pop   (pop),
      .rdata (m.m_data),
      .count (m.count),
      .empty (empty),
      .full  (full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         rx_rdy_clr <= 1'b0;
      end else begin
         rx_rdy_clr <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_rdy) begin
                  rx_rdy_clr <= 1'b1;
                  state      <= S_CLR;
               end
            end
            S_CLR:  state <= S_WAIT;
            S_WAIT: begin
               if (rx_rdy) begin
                  rx_rdy_clr <= 1'b1;
                  state      <= S_CLR;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ovr_q <= 1'b0;
      else if (drop)    ovr_q <= 1'b1;
      else if (m.ovr_clr) ovr_q <= 1'b0;
   end

   // Timer disarms after firing so a quiet line yields one event per push
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
         armed <= 1'b1;
         irq_q <= 1'b0;
      end else begin
         irq_q <= 1'b0;
         if (push) begin
            timer <= '0;
            armed <= 1'b1;
         end else if (pop || !rx_line || empty) begin
            timer <= '0;
         end else if (baud_tick2 && armed) begin
            if (timer == TMR_W'(IDLE_TICKS - 1)) begin
               timer <= TMR_W'(IDLE_TICKS);
               irq_q <= 1'b1;
               armed <= 1'b0;
            end else begin
               timer <= timer + 1'b1;
            end
         end
      end
   end

   assign m.m_valid  = !empty;
   assign m.overrun  = ovr_q;
   assign m.idle_irq = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed and randomized bench for uart_rx_ctrl against a queue-based
// reference of the buffered bytes, overrun flag and idle-event timing.
module tb_uart_rx_ctrl;

   localparam int DEPTH      = 8;
   localparam int IDLE_TICKS = 160;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       baud_tick2 = 1'b0;
   logic       rx_line = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_rdy = 1'b0;
   logic       rx_rdy_clr;

   uart_rx_ctrl_if #(.DEPTH(DEPTH)) bus ();

   uart_rx_ctrl #(.DEPTH(DEPTH), .IDLE_TICKS(IDLE_TICKS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .baud_tick2 (baud_tick2),
      .rx_line    (rx_line),
      .rx_data    (rx_data),
      .rx_rdy     (rx_rdy),
      .rx_rdy_clr (rx_rdy_clr),
      .m          (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] q[$];
   bit         mdl_ovr;
   int         tests;
   int         fails;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_valid"}, 32'(bus.m_valid), 32'(q.size() != 0));
      chk({tag, "_count"}, 32'(bus.count), 32'(q.size()));
      chk({tag, "_ovr"}, 32'(bus.overrun), 32'(mdl_ovr));
      if (q.size() != 0) chk({tag, "_data"}, 32'(bus.m_data), 32'(q[0]));
   endtask

   // Reference: optional pop of the head, then the byte is kept if there is room
   task automatic model_capture(input logic [7:0] d, input bit pop, input bit oclr);
      bit dropped;
      if (pop && q.size() != 0) void'(q.pop_front());
      dropped = (q.size() >= DEPTH);
      if (!dropped) q.push_back(d);
      if (dropped) mdl_ovr = 1'b1;
      else if (oclr) mdl_ovr = 1'b0;
   endtask

   task automatic deliver(input logic [7:0] d, input bit pop, input bit oclr, input string tag);
      chk({tag, "_clr_pre"}, 32'(rx_rdy_clr), 32'd0);
      check_state({tag, "_pre"});
      rx_data     = d;
      rx_rdy      = 1'b1;
      bus.m_ready = pop;
      bus.ovr_clr = oclr;
      @(posedge clk);
      model_capture(d, pop, oclr);
      @(negedge clk);
      chk({tag, "_clr_hi"}, 32'(rx_rdy_clr), 32'd1);
      check_state({tag, "_post"});
      rx_rdy      = 1'b0;
      bus.m_ready = 1'b0;
      bus.ovr_clr = 1'b0;
      @(negedge clk);
      chk({tag, "_clr_lo"}, 32'(rx_rdy_clr), 32'd0);
      @(negedge clk);
   endtask

   task automatic idle_cycle(input bit ready, input string tag);
      check_state(tag);
      bus.m_ready = ready;
      @(posedge clk);
      if (ready && q.size() != 0) void'(q.pop_front());
      @(negedge clk);
      bus.m_ready = 1'b0;
   endtask

   task automatic clear_ovr();
      bus.ovr_clr = 1'b1;
      @(posedge clk);
      mdl_ovr = 1'b0;
      @(negedge clk);
      bus.ovr_clr = 1'b0;
   endtask

   // One baud tick followed by one quiet cycle; reports the pulse count seen
   task automatic run_ticks(input int n, input bit line, input int exp_at, input string tag);
      int pulses;
      int at;
      pulses = 0;
      at = 0;
      for (int i = 1; i <= n; i++) begin
         rx_line    = line;
         baud_tick2 = 1'b1;
         @(negedge clk);
         baud_tick2 = 1'b0;
         if (bus.idle_irq) begin
            pulses++;
            at = i;
         end
         @(negedge clk);
         if (bus.idle_irq) pulses++;
      end
      rx_line = 1'b1;
      chk({tag, "_pulses"}, 32'(pulses), (exp_at != 0) ? 32'd1 : 32'd0);
      if (exp_at != 0) chk({tag, "_at"}, 32'(at), 32'(exp_at));
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] clr_seq [5];
      logic [7:0] exp_seq [5];
      tests   = 0;
      fails   = 0;
      mdl_ovr = 1'b0;
      bus.m_ready = 1'b0;
      bus.ovr_clr = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_clr", 32'(rx_rdy_clr), 32'd0);
      chk("rst_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_data", 32'(bus.m_data), 32'd0);
      chk("rst_ovr", 32'(bus.overrun), 32'd0);
      chk("rst_irq", 32'(bus.idle_irq), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single byte
      deliver(8'hA5, 1'b0, 1'b0, "single");
      idle_cycle(1'b1, "single_pop");
      idle_cycle(1'b0, "single_empty");

      // Fill past capacity, then drain in order
      for (int i = 1; i <= 9; i++) deliver(8'(i), 1'b0, 1'b0, "fill");
      chk("fill_ovr", 32'(bus.overrun), 32'd1);
      chk("fill_count", 32'(bus.count), 32'd8);
      for (int i = 1; i <= 8; i++) begin
         chk("drain_order", 32'(bus.m_data), 32'(i));
         idle_cycle(1'b1, "drain");
      end
      idle_cycle(1'b0, "drain_empty");

      // Full with a pop in the capture cycle, then drop coincident with clear
      clear_ovr();
      for (int i = 0; i < DEPTH; i++) deliver(8'($urandom), 1'b0, 1'b0, "fill2");
      deliver(8'h5A, 1'b1, 1'b0, "full_pop");
      chk("full_pop_count", 32'(bus.count), 32'd8);
      chk("full_pop_ovr", 32'(bus.overrun), 32'd0);
      deliver(8'hEE, 1'b0, 1'b1, "drop_vs_clr");
      chk("drop_vs_clr_ovr", 32'(bus.overrun), 32'd1);
      for (int i = 0; i < DEPTH; i++) idle_cycle(1'b1, "drain2");
      clear_ovr();
      idle_cycle(1'b0, "drain2_empty");

      // Receiver completes a second byte in the same cycle as the clear
      exp_seq = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0};
      rx_data = 8'h3C;
      rx_rdy  = 1'b1;
      @(posedge clk);
      model_capture(8'h3C, 1'b0, 1'b0);
      @(negedge clk);
      clr_seq[0] = 8'(rx_rdy_clr);
      rx_data = 8'hC3;
      @(posedge clk);
      @(negedge clk);
      clr_seq[1] = 8'(rx_rdy_clr);
      @(posedge clk);
      model_capture(8'hC3, 1'b0, 1'b0);
      @(negedge clk);
      clr_seq[2] = 8'(rx_rdy_clr);
      rx_rdy = 1'b0;
      for (int i = 3; i < 5; i++) begin
         @(negedge clk);
         clr_seq[i] = 8'(rx_rdy_clr);
      end
      for (int i = 0; i < 5; i++) chk("race_clr", 32'(clr_seq[i]), 32'(exp_seq[i]));
      chk("race_count", 32'(bus.count), 32'd2);
      idle_cycle(1'b1, "race_pop1");
      idle_cycle(1'b1, "race_pop2");
      idle_cycle(1'b0, "race_empty");

      // Idle event
      deliver(8'h55, 1'b0, 1'b0, "idle_byte");
      run_ticks(IDLE_TICKS, 1'b1, IDLE_TICKS, "idle_fire");
      run_ticks(50, 1'b1, 0, "idle_quiet");
      deliver(8'h66, 1'b0, 1'b0, "idle_rearm");
      run_ticks(99, 1'b1, 0, "idle_pre");
      run_ticks(1, 1'b0, 0, "idle_low");
      run_ticks(IDLE_TICKS - 1, 1'b1, 0, "idle_restart");
      run_ticks(1, 1'b1, 1, "idle_refire");
      idle_cycle(1'b1, "idle_pop1");
      idle_cycle(1'b1, "idle_pop2");

      // Randomized traffic
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom), "rnd_idle");
         else deliver(8'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), "rnd");
      end
      for (int i = 0; i < DEPTH; i++) idle_cycle(1'b1, "rnd_drain");
      idle_cycle(1'b0, "rnd_empty");

      // Asynchronous reset while a clear pulse is in flight
      if (!mdl_ovr) begin
         for (int i = 0; i <= DEPTH; i++) deliver(8'(i), 1'b0, 1'b0, "pre_ovr");
         for (int i = 0; i < DEPTH; i++) idle_cycle(1'b1, "pre_ovr_drain");
      end
      deliver(8'h11, 1'b0, 1'b0, "mid1");
      deliver(8'h22, 1'b0, 1'b0, "mid2");
      rx_data = 8'h77;
      rx_rdy  = 1'b1;
      @(posedge clk);
      model_capture(8'h77, 1'b0, 1'b0);
      @(negedge clk);
      chk("mid_count", 32'(bus.count), 32'd3);
      chk("mid_clr", 32'(rx_rdy_clr), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_clr", 32'(rx_rdy_clr), 32'd0);
      chk("arst_valid", 32'(bus.m_valid), 32'd0);
      chk("arst_count", 32'(bus.count), 32'd0);
      chk("arst_data", 32'(bus.m_data), 32'd0);
      chk("arst_ovr", 32'(bus.overrun), 32'd0);
      chk("arst_irq", 32'(bus.idle_irq), 32'd0);
      q.delete();
      mdl_ovr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      model_capture(8'h77, 1'b0, 1'b0);
      @(negedge clk);
      chk("post_rst_clr", 32'(rx_rdy_clr), 32'd1);
      check_state("post_rst");
      rx_rdy = 1'b0;
      @(negedge clk);
      @(negedge clk);
      idle_cycle(1'b1, "post_rst_pop");
      idle_cycle(1'b0, "post_rst_empty");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
